// File: rtl/vsync_rate_monitor_pkg.sv
// Shared types and 100 MHz-referenced timing constants for the vsync rate monitor.
// Nominal GBA frame periods are expressed in 100 MHz reference-clock cycles.
package vsync_rate_monitor_pkg;

  typedef enum logic [1:0] {
    ST_NO_SIGNAL = 2'd0,
    ST_ACQUIRE   = 2'd1,
    ST_LOCKED    = 2'd2
  } mon_state_t;

  localparam int unsigned CLK_HZ           = 100_000_000;
  localparam int unsigned PERIOD_60HZ      = 1_666_667;
  localparam int unsigned PERIOD_59HZ      = 1_674_200;
  localparam int unsigned PERIOD_SPLIT_DEF = (PERIOD_60HZ + PERIOD_59HZ) / 2;
  localparam int unsigned HYST_DEF         = 1_000;
  localparam int unsigned PERIOD_MIN_DEF   = 1_600_000;
  localparam int unsigned PERIOD_MAX_DEF   = 1_750_000;
  localparam int unsigned TIMEOUT_DEF      = 2_000_000;
  localparam int unsigned CONFIRM_DEF      = 4;
  localparam int unsigned CNT_W_DEF        = 21;
  localparam int unsigned SYNC_STAGES_DEF  = 2;

  // Inside the hysteresis band the current classification is kept.
  function automatic logic classify_period(input int unsigned meas,
                                           input int unsigned split,
                                           input int unsigned hyst,
                                           input logic        hold);
    logic cand;
    if (meas > split + hyst) begin
      cand = 1'b1;
    end else if (meas < split - hyst) begin
      cand = 1'b0;
    end else begin
      cand = hold;
    end
    return cand;
  endfunction

endpackage

// File: rtl/vsync_rate_monitor_edge_sync.sv
// Multi-flop synchronizer for the raw vsync pin with a registered falling-edge pulse.
module vsync_edge_sync
  import vsync_rate_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic fe
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   fe_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
      fe_reg   <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], vsync};
      prev_reg <= sync_reg[SYNC_STAGES-1];
      fe_reg   <= prev_reg & ~sync_reg[SYNC_STAGES-1];
    end
  end

  assign fe = fe_reg;

endmodule

// File: rtl/vsync_rate_monitor.sv
// Measures the vsync frame period on the fixed reference clock and classifies it
// as 60 Hz or 59.7 Hz class, with hysteresis, multi-frame confirmation and loss detection.
module vsync_rate_monitor
  import vsync_rate_monitor_pkg::*;
#(
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int unsigned PERIOD_MIN     = PERIOD_MIN_DEF,
  parameter int unsigned PERIOD_MAX     = PERIOD_MAX_DEF,
  parameter int unsigned PERIOD_SPLIT   = PERIOD_SPLIT_DEF,
  parameter int unsigned HYST           = HYST_DEF,
  parameter int unsigned CONFIRM_FRAMES = CONFIRM_DEF,
  parameter int unsigned TIMEOUT        = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync,
  output logic             framerate,
  output logic             rateChange,
  output logic             locked,
  output logic             signalLost,
  output logic [CNT_W-1:0] period,
  output logic             periodValid
);

  localparam int unsigned      STREAK_W  = $clog2(CONFIRM_FRAMES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(PERIOD_MAX);
  localparam logic [STREAK_W-1:0] CONFIRM_C = STREAK_W'(CONFIRM_FRAMES);

  logic                fe;
  mon_state_t          state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [CNT_W-1:0]    meas;
  logic [STREAK_W-1:0] streak_reg, streak_next, streak_inc, acq_streak;
  logic                last_cand_reg, last_cand_next;
  logic                framerate_reg, framerate_next;
  logic                rate_change_reg, rate_change_next;
  logic                locked_reg, signal_lost_reg;
  logic [CNT_W-1:0]    period_reg, period_next;
  logic                period_valid_reg, period_valid_next;
  logic                cand;
  logic                in_range;

  vsync_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .vsync(vsync),
    .fe   (fe)
  );

  // Inclusive count: the edge cycle itself belongs to the frame just ended.
  assign meas       = cnt_reg + CNT_W'(1);
  assign in_range   = (meas >= MIN_C) && (meas <= MAX_C);
  assign cand       = classify_period(32'(meas), PERIOD_SPLIT, HYST, framerate_reg);
  assign streak_inc = streak_reg + STREAK_W'(1);
  assign acq_streak = (cand == last_cand_reg) ? streak_inc : STREAK_W'(1);

  always_comb begin
    state_next        = state_reg;
    cnt_next          = (cnt_reg == TIMEOUT_C) ? cnt_reg : cnt_reg + CNT_W'(1);
    streak_next       = streak_reg;
    last_cand_next    = last_cand_reg;
    framerate_next    = framerate_reg;
    rate_change_next  = 1'b0;
    period_next       = period_reg;
    period_valid_next = 1'b0;

    if (fe) begin
      cnt_next = '0;
      case (state_reg)
        ST_NO_SIGNAL: begin
          // First edge only opens a measurement window; the frame before it is partial.
          state_next  = ST_ACQUIRE;
          streak_next = '0;
        end
        ST_ACQUIRE: begin
          if (in_range) begin
            period_next       = meas;
            period_valid_next = 1'b1;
            last_cand_next    = cand;
            if (acq_streak == CONFIRM_C) begin
              state_next       = ST_LOCKED;
              framerate_next   = cand;
              rate_change_next = (cand != framerate_reg);
              streak_next      = '0;
            end else begin
              streak_next = acq_streak;
            end
          end else begin
            streak_next = '0;
          end
        end
        ST_LOCKED: begin
          if (in_range) begin
            period_next       = meas;
            period_valid_next = 1'b1;
            if (cand != framerate_reg) begin
              if (streak_inc == CONFIRM_C) begin
                framerate_next   = ~framerate_reg;
                rate_change_next = 1'b1;
                streak_next      = '0;
              end else begin
                streak_next = streak_inc;
              end
            end else begin
              streak_next = '0;
            end
          end else begin
            state_next  = ST_ACQUIRE;
            streak_next = '0;
          end
        end
        default: begin
          state_next  = ST_NO_SIGNAL;
          streak_next = '0;
        end
      endcase
    end else if (cnt_reg == TIMEOUT_C) begin
      state_next  = ST_NO_SIGNAL;
      streak_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_NO_SIGNAL;
      cnt_reg          <= '0;
      streak_reg       <= '0;
      last_cand_reg    <= 1'b0;
      framerate_reg    <= 1'b0;
      rate_change_reg  <= 1'b0;
      locked_reg       <= 1'b0;
      signal_lost_reg  <= 1'b1;
      period_reg       <= '0;
      period_valid_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      streak_reg       <= streak_next;
      last_cand_reg    <= last_cand_next;
      framerate_reg    <= framerate_next;
      rate_change_reg  <= rate_change_next;
      locked_reg       <= (state_next == ST_LOCKED);
      signal_lost_reg  <= (state_next == ST_NO_SIGNAL);
      period_reg       <= period_next;
      period_valid_reg <= period_valid_next;
    end
  end

  assign framerate   = framerate_reg;
  assign rateChange  = rate_change_reg;
  assign locked      = locked_reg;
  assign signalLost  = signal_lost_reg;
  assign period      = period_reg;
  assign periodValid = period_valid_reg;

endmodule

// File: tb/tb_vsync_rate_monitor.sv
// Self-checking bench: scaled-down periods, directed scenarios plus randomized frame runs
// checked every cycle against an event-level model of the monitor.
module tb_vsync_rate_monitor;

  localparam int SYNC  = 2;
  localparam int CNT_W = 9;
  localparam int PMIN  = 100;
  localparam int PMAX  = 200;
  localparam int SPLIT = 150;
  localparam int HYST  = 5;
  localparam int CONF  = 4;
  localparam int TO    = 250;

  localparam int LOST = 0;
  localparam int ACQ  = 1;
  localparam int LOCK = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             vsync;
  logic             framerate;
  logic             rateChange;
  logic             locked;
  logic             signalLost;
  logic [CNT_W-1:0] period;
  logic             periodValid;

  always #5 clk = ~clk;

  vsync_rate_monitor #(
    .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .PERIOD_MIN(PMIN), .PERIOD_MAX(PMAX),
    .PERIOD_SPLIT(SPLIT), .HYST(HYST), .CONFIRM_FRAMES(CONF), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .framerate(framerate), .rateChange(rateChange),
    .locked(locked), .signalLost(signalLost), .period(period), .periodValid(periodValid)
  );

  int cyc = 0, tests = 0, fails = 0, pv_cnt = 0, rc_cnt = 0;
  bit chk_en = 0;
  int fe_q[$];

  // Model state: frame-level view of the monitor
  int m_last_ref, m_mode, m_streak, m_fr, m_last_cand, m_rc, m_period, m_pv;
  int gap, meas, cand;
  bit is_fe, in_rng;

  task automatic model_reset();
    m_mode = LOST; m_streak = 0; m_fr = 0; m_last_cand = 0;
    m_rc = 0; m_period = 0; m_pv = 0;
    fe_q.delete();
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_rc = 0; m_pv = 0; is_fe = 0;
      if (fe_q.size() > 0 && fe_q[0] == cyc) begin
        is_fe = 1;
        void'(fe_q.pop_front());
      end
      gap = cyc - m_last_ref;
      if (is_fe) begin
        meas = (gap > TO + 1) ? TO + 1 : gap;
        m_last_ref = cyc;
        in_rng = (meas >= PMIN) && (meas <= PMAX);
        cand = (meas > SPLIT + HYST) ? 1 : (meas < SPLIT - HYST) ? 0 : m_fr;
        if (m_mode == LOST || !in_rng) begin
          m_mode = ACQ; m_streak = 0;
        end else begin
          m_period = meas; m_pv = 1;
          if (m_mode == ACQ) begin
            m_streak = (cand == m_last_cand) ? m_streak + 1 : 1;
            m_last_cand = cand;
            if (m_streak == CONF) begin
              m_mode = LOCK; m_rc = (m_fr != cand) ? 1 : 0; m_fr = cand; m_streak = 0;
            end
          end else begin
            m_streak = (cand != m_fr) ? m_streak + 1 : 0;
            if (m_streak == CONF) begin
              m_fr = 1 - m_fr; m_rc = 1; m_streak = 0;
            end
          end
        end
      end else if (gap >= TO + 1) begin
        m_mode = LOST; m_streak = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      tests++;
      if (framerate !== m_fr[0] || rateChange !== m_rc[0] || locked !== 1'(m_mode == LOCK) ||
          signalLost !== 1'(m_mode == LOST) || period !== CNT_W'(m_period) || periodValid !== m_pv[0]) begin
        fails++;
        $display("FAIL outputs @cycle %0d: got fr=%0d rc=%0d lock=%0d lost=%0d period=%0d pv=%0d, expected fr=%0d rc=%0d lock=%0d lost=%0d period=%0d pv=%0d",
                 cyc, framerate, rateChange, locked, signalLost, period, periodValid,
                 m_fr, m_rc, (m_mode == LOCK), (m_mode == LOST), m_period, m_pv);
      end
      if (periodValid === 1'b1) begin
        pv_cnt++;
        $display("[TB] frame @cycle %0d: period=%0d framerate=%0d locked=%0d rateChange=%0d",
                 cyc, period, framerate, locked, rateChange);
      end
      if (rateChange === 1'b1) rc_cnt++;
      if (fails >= 50) begin
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  end

  task automatic chk(string name, int got, int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One frame of length p starting with a falling edge; vsync low for 10 cycles.
  task automatic frame(int p);
    @(posedge clk); #1;
    vsync = 1'b0;
    fe_q.push_back(cyc + SYNC + 2);
    repeat (10) @(posedge clk);
    #1;
    vsync = 1'b1;
    repeat (p - 11) @(posedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    vsync = 1'b1;
    model_reset();
    #1;
    chk("rst_framerate", int'(framerate), 0);
    chk("rst_rateChange", int'(rateChange), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_signalLost", int'(signalLost), 1);
    chk("rst_period", int'(period), 0);
    chk("rst_periodValid", int'(periodValid), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_last_ref = cyc;
    repeat (5) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int r, p, run;
    rst = 1'b1;
    vsync = 1'b1;
    model_reset();
    chk_en = 1;
    do_reset();

    // No edges: stays lost, nothing emitted
    idle(300);
    chk("p1_signalLost", int'(signalLost), 1);
    chk("p1_locked", int'(locked), 0);
    chk("p1_framerate", int'(framerate), 0);
    chk("p1_pv_count", pv_cnt, 0);

    // 59.7-class frames: first edge discarded, 4 valid frames lock at framerate 1
    repeat (5) frame(190);
    chk("p2_locked", int'(locked), 1);
    chk("p2_framerate", int'(framerate), 1);
    chk("p2_period", int'(period), 190);
    chk("p2_pv_count", pv_cnt, 4);
    chk("p2_rc_count", rc_cnt, 1);

    // Switch to 60-class: three frames hold, the fourth toggles
    repeat (4) frame(120);
    chk("p3_hold_framerate", int'(framerate), 1);
    chk("p3_hold_rc_count", rc_cnt, 1);
    frame(120);
    chk("p3_framerate", int'(framerate), 0);
    chk("p3_rc_count", rc_cnt, 2);

    // In-band alternation holds the classification
    for (int i = 0; i < 6; i++) frame((i % 2 == 0) ? 148 : 152);
    chk("p4_framerate", int'(framerate), 0);
    chk("p4_locked", int'(locked), 1);
    chk("p4_rc_count", rc_cnt, 2);

    // Out-of-range frame drops lock, period held, then relock
    frame(60);
    frame(120);
    chk("p5_locked", int'(locked), 0);
    chk("p5_period", int'(period), 152);
    chk("p5_framerate", int'(framerate), 0);
    repeat (4) frame(120);
    chk("p5_relocked", int'(locked), 1);
    chk("p5_rc_count", rc_cnt, 2);

    // vsync stops: timeout, period held; then reset mid-frame
    idle(300);
    chk("p6_signalLost", int'(signalLost), 1);
    chk("p6_locked", int'(locked), 0);
    chk("p6_period", int'(period), 120);
    frame(150);
    do_reset();

    // Randomized runs of same-class frames, with occasional resets
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 99);
      run = $urandom_range(1, 8);
      for (int j = 0; j < run; j++) begin
        if (r < 30)      p = $urandom_range(170, 200);
        else if (r < 60) p = $urandom_range(100, 140);
        else if (r < 75) p = $urandom_range(140, 160);
        else if (r < 85) p = $urandom_range(40, 99);
        else if (r < 92) p = $urandom_range(201, 249);
        else if (r < 96) p = $urandom_range(250, 252);
        else             p = $urandom_range(253, 320);
        frame(p);
      end
      if ($urandom_range(0, 29) == 0) do_reset();
    end
    idle(300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
